multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/multicycle_controller_if.sv | 38 +++
 rtl/mc_output_decode.sv | 82 ++++++++
 rtl/multicycle_controller.sv | 89 ++++++++
 tb/tb_multicycle_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode and control-field encodings for the multicycle controller
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_EXEC_I    = 4'd3,
        ST_MEM_ADDR  = 4'd4,
        ST_MEM_READ  = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_WB_ALU    = 4'd7,
        ST_WB_MEM    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_HALT      = 4'd11
    } mc_state_e;

    localparam logic [3:0] OP_RALU   = 4'b0000;
    localparam logic [3:0] OP_IALU   = 4'b0001;
    localparam logic [3:0] OP_LW     = 4'b0010;
    localparam logic [3:0] OP_SW     = 4'b0011;
    localparam logic [3:0] OP_BRANCH = 4'b0100;
    localparam logic [3:0] OP_JAL    = 4'b0101;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_CONST2 = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BROFF  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Condition codes understood by the external branch controller
    localparam logic [1:0] BR_BEQ = 2'b00;
    localparam logic [1:0] BR_BNE = 2'b01;
    localparam logic [1:0] BR_BLT = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       iord;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic [1:0] branch_funct;
        logic       illegal;
    } mc_ctrl_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/memory inputs and datapath control outputs of the controller
interface multicycle_controller_if;

    logic [3:0] opcode;
    logic [1:0] funct;
    logic       mem_ready;

    logic       IRWrite;
    logic       PCWrite;
    logic       branch;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic       IorD;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [1:0] Branch_funct;
    logic       illegal;
    logic [3:0] state;

    modport slave (
        input  opcode, funct, mem_ready,
        output IRWrite, PCWrite, branch, MemRead, MemWrite, RegWrite, IorD,
               MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, Branch_funct,
               illegal, state
    );

    modport master (
        output opcode, funct, mem_ready,
        input  IRWrite, PCWrite, branch, MemRead, MemWrite, RegWrite, IorD,
               MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, Branch_funct,
               illegal, state
    );

endinterface

// File: rtl/mc_output_decode.sv
// rtl/mc_output_decode.sv - combinational state-to-control decoder
// Only FETCH looks at mem_ready and only BRANCH looks at funct; everything else is pure state decode.
module mc_output_decode
    import mc_pkg::*;
(
    input  logic [3:0] i_state,
    input  logic       i_mem_ready,
    input  logic [1:0] i_funct,
    output mc_ctrl_t   o_ctrl
);

    always_comb begin
        o_ctrl              = '0;
        o_ctrl.branch_funct = BR_BEQ;
        case (i_state)
            ST_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.iord      = 1'b0;
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_CONST2;
                o_ctrl.alu_op    = ALUOP_ADD;
                o_ctrl.pc_source = PCSRC_ALU;
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_ctrl.alu_src_a = 1'b0;
                o_ctrl.alu_src_b = SRCB_BROFF;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_REG;
                o_ctrl.alu_op    = ALUOP_RFUNCT;
            end
            ST_EXEC_I: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_IFUNCT;
            end
            ST_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.iord     = 1'b1;
            end
            ST_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.iord      = 1'b1;
            end
            ST_WB_ALU: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b0;
            end
            ST_WB_MEM: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                // funct 11 is forwarded as-is; the branch controller treats it as not-taken
                o_ctrl.alu_src_a    = 1'b1;
                o_ctrl.alu_src_b    = SRCB_REG;
                o_ctrl.alu_op       = ALUOP_SUB;
                o_ctrl.branch       = 1'b1;
                o_ctrl.pc_source    = PCSRC_ALUOUT;
                o_ctrl.branch_funct = i_funct;
            end
            ST_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            ST_HALT: begin
                o_ctrl.illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM: state register, next-state logic, reset gating
module multicycle_controller
    import mc_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.slave  bus
);

    localparam logic [3:0] S_FETCH     = ST_FETCH;
    localparam logic [3:0] S_DECODE    = ST_DECODE;
    localparam logic [3:0] S_EXEC_R    = ST_EXEC_R;
    localparam logic [3:0] S_EXEC_I    = ST_EXEC_I;
    localparam logic [3:0] S_MEM_ADDR  = ST_MEM_ADDR;
    localparam logic [3:0] S_MEM_READ  = ST_MEM_READ;
    localparam logic [3:0] S_MEM_WRITE = ST_MEM_WRITE;
    localparam logic [3:0] S_WB_ALU    = ST_WB_ALU;
    localparam logic [3:0] S_WB_MEM    = ST_WB_MEM;
    localparam logic [3:0] S_BRANCH    = ST_BRANCH;
    localparam logic [3:0] S_JUMP      = ST_JUMP;
    localparam logic [3:0] S_HALT      = ST_HALT;

    logic [3:0] r_state;
    logic [3:0] w_next;
    mc_ctrl_t   w_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:     if (bus.mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RALU:          w_next = S_EXEC_R;
                    OP_IALU:          w_next = S_EXEC_I;
                    OP_LW, OP_SW:     w_next = S_MEM_ADDR;
                    OP_BRANCH:        w_next = S_BRANCH;
                    OP_JAL:           w_next = S_JUMP;
                    default:          w_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I:    w_next = S_WB_ALU;
            S_MEM_ADDR:  w_next = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (bus.mem_ready) w_next = S_WB_MEM;
            S_MEM_WRITE: if (bus.mem_ready) w_next = S_FETCH;
            S_WB_ALU,
            S_WB_MEM,
            S_BRANCH,
            S_JUMP:      w_next = S_FETCH;
            S_HALT:      w_next = S_HALT;
            default:     w_next = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (bus.mem_ready),
        .i_funct     (bus.funct),
        .o_ctrl      (w_ctrl)
    );

    // Architectural side-effect strobes are suppressed for the whole reset cycle
    assign bus.IRWrite      = w_ctrl.ir_write  & ~rst;
    assign bus.PCWrite      = w_ctrl.pc_write  & ~rst;
    assign bus.branch       = w_ctrl.branch    & ~rst;
    assign bus.MemWrite     = w_ctrl.mem_write & ~rst;
    assign bus.RegWrite     = w_ctrl.reg_write & ~rst;
    assign bus.MemRead      = w_ctrl.mem_read;
    assign bus.IorD         = w_ctrl.iord;
    assign bus.MemtoReg     = w_ctrl.mem_to_reg;
    assign bus.ALUSrcA      = w_ctrl.alu_src_a;
    assign bus.ALUSrcB      = w_ctrl.alu_src_b;
    assign bus.ALUOp        = w_ctrl.alu_op;
    assign bus.PCSource     = w_ctrl.pc_source;
    assign bus.Branch_funct = w_ctrl.branch_funct;
    assign bus.illegal      = w_ctrl.illegal;
    assign bus.state        = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller (halt and return-to-fetch variants)
module tb_multicycle_controller;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst_h = 1'b1;
    logic       rst_f = 1'b1;
    logic [3:0] opcode = 4'd0;
    logic [1:0] funct = 2'd0;
    logic       mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [21:0] h;
        logic [21:0] f;
    } exp_t;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [1:0] fn;
    } plan_t;

    exp_t  sb_q[$];
    plan_t plan_q[$];

    always #5 clk = ~clk;

    multicycle_controller_if if_h ();
    multicycle_controller_if if_f ();

    assign if_h.opcode = opcode;
    assign if_h.funct = funct;
    assign if_h.mem_ready = mem_ready;
    assign if_f.opcode = opcode;
    assign if_f.funct = funct;
    assign if_f.mem_ready = mem_ready;

    multicycle_controller #(.ILLEGAL_HALT(1'b1)) dut_h (.clk(clk), .rst(rst_h), .bus(if_h.slave));
    multicycle_controller #(.ILLEGAL_HALT(1'b0)) dut_f (.clk(clk), .rst(rst_f), .bus(if_f.slave));

    function automatic logic [21:0] exp_vec(logic [3:0] st, logic mr, logic [1:0] fn, logic rs);
        logic irw, pcw, br, mrd, mwr, rw, iord, m2r, sa, ill;
        logic [1:0] sb, aop, pcs, bf;
        {irw, pcw, br, mrd, mwr, rw, iord, m2r, sa, ill} = '0;
        {sb, aop, pcs, bf} = '0;
        case (st)
            ST_FETCH:     begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            ST_DECODE:    sb = 2'b11;
            ST_EXEC_R:    begin sa = 1; aop = 2'b10; end
            ST_EXEC_I:    begin sa = 1; sb = 2'b10; aop = 2'b11; end
            ST_MEM_ADDR:  begin sa = 1; sb = 2'b10; end
            ST_MEM_READ:  begin mrd = 1; iord = 1; end
            ST_MEM_WRITE: begin mwr = 1; iord = 1; end
            ST_WB_ALU:    rw = 1;
            ST_WB_MEM:    begin rw = 1; m2r = 1; end
            ST_BRANCH:    begin sa = 1; aop = 2'b01; br = 1; pcs = 2'b01; bf = fn; end
            ST_JUMP:      begin pcw = 1; pcs = 2'b10; end
            ST_HALT:      ill = 1;
            default: ;
        endcase
        if (rs) {irw, pcw, br, mwr, rw} = '0;
        return {st, irw, pcw, br, mrd, mwr, rw, iord, m2r, sa, sb, aop, pcs, bf, ill};
    endfunction

    // One clock cycle: apply the current inputs, record what both DUTs must show, advance.
    task automatic step(input logic [3:0] sh, input logic rh, input logic [3:0] sf, input logic rf);
        exp_t e;
        rst_h = rh;
        rst_f = rf;
        e.h = exp_vec(sh, mem_ready, funct, rh);
        e.f = exp_vec(sf, mem_ready, funct, rf);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic push_plan(input logic [3:0] st, input logic mr, input logic [1:0] fn);
        plan_t p;
        p.st = st;
        p.mr = mr;
        p.fn = fn;
        plan_q.push_back(p);
    endtask

    // Cycle-by-cycle state sequence of one instruction, built from the latency rules.
    task automatic plan_instr(input logic [3:0] op, input logic [1:0] fn, input int wf, input int wm,
                              input bit halt_mode);
        for (int i = 0; i < wf; i++) push_plan(ST_FETCH, 1'b0, 2'($urandom));
        push_plan(ST_FETCH, 1'b1, 2'($urandom));
        push_plan(ST_DECODE, 1'($urandom), 2'($urandom));
        case (op)
            4'd0: begin
                push_plan(ST_EXEC_R, 1'($urandom), 2'($urandom));
                push_plan(ST_WB_ALU, 1'($urandom), 2'($urandom));
            end
            4'd1: begin
                push_plan(ST_EXEC_I, 1'($urandom), 2'($urandom));
                push_plan(ST_WB_ALU, 1'($urandom), 2'($urandom));
            end
            4'd2: begin
                push_plan(ST_MEM_ADDR, 1'($urandom), 2'($urandom));
                for (int i = 0; i < wm; i++) push_plan(ST_MEM_READ, 1'b0, 2'($urandom));
                push_plan(ST_MEM_READ, 1'b1, 2'($urandom));
                push_plan(ST_WB_MEM, 1'($urandom), 2'($urandom));
            end
            4'd3: begin
                push_plan(ST_MEM_ADDR, 1'($urandom), 2'($urandom));
                for (int i = 0; i < wm; i++) push_plan(ST_MEM_WRITE, 1'b0, 2'($urandom));
                push_plan(ST_MEM_WRITE, 1'b1, 2'($urandom));
            end
            4'd4: push_plan(ST_BRANCH, 1'($urandom), fn);
            4'd5: push_plan(ST_JUMP, 1'($urandom), 2'($urandom));
            default: if (halt_mode) for (int i = 0; i < 10; i++) push_plan(ST_HALT, 1'($urandom), 2'($urandom));
        endcase
    endtask

    task automatic run_plan(input bit sel_f);
        plan_t p;
        while (plan_q.size() > 0) begin
            p = plan_q.pop_front();
            mem_ready = p.mr;
            funct = p.fn;
            if (sel_f) step(ST_FETCH, 1'b1, p.st, 1'b0);
            else       step(p.st, 1'b0, ST_FETCH, 1'b1);
        end
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [1:0] fn, input int wf, input int wm,
                            input bit sel_f);
        opcode = op;
        plan_instr(op, fn, wf, wm, !sel_f);
        run_plan(sel_f);
    endtask

    initial begin : monitor
        exp_t e;
        logic [21:0] act_h, act_f;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act_h = {if_h.state, if_h.IRWrite, if_h.PCWrite, if_h.branch, if_h.MemRead, if_h.MemWrite,
                         if_h.RegWrite, if_h.IorD, if_h.MemtoReg, if_h.ALUSrcA, if_h.ALUSrcB, if_h.ALUOp,
                         if_h.PCSource, if_h.Branch_funct, if_h.illegal};
                act_f = {if_f.state, if_f.IRWrite, if_f.PCWrite, if_f.branch, if_f.MemRead, if_f.MemWrite,
                         if_f.RegWrite, if_f.IorD, if_f.MemtoReg, if_f.ALUSrcA, if_f.ALUSrcB, if_f.ALUOp,
                         if_f.PCSource, if_f.Branch_funct, if_f.illegal};
                checks += 2;
                if (act_h !== e.h) begin
                    errors++;
                    $display("FAIL halt_dut cyc=%0d actual state/ctrl=%h required=%h", cyc, act_h, e.h);
                end
                if (act_f !== e.f) begin
                    errors++;
                    $display("FAIL fetch_dut cyc=%0d actual state/ctrl=%h required=%h", cyc, act_f, e.f);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int wait_cnt;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom);
            funct = 2'($urandom);
            step(ST_FETCH, 1'b1, ST_FETCH, 1'b1);
        end

        do_instr(4'd0, 2'b00, 2, 0, 1'b0);
        do_instr(4'd2, 2'b00, 0, 3, 1'b0);
        do_instr(4'd4, 2'b01, 0, 0, 1'b0);
        do_instr(4'd4, 2'b11, 1, 0, 1'b0);

        // SW interrupted by reset while waiting on memory
        opcode = 4'd3;
        plan_instr(4'd3, 2'b00, 0, 3, 1'b1);
        repeat (3) void'(plan_q.pop_back());
        run_plan(1'b0);
        mem_ready = 1'b0;
        step(ST_MEM_WRITE, 1'b1, ST_FETCH, 1'b1);

        for (int i = 0; i < 150; i++)
            do_instr(4'($urandom_range(0, 5)), 2'($urandom), $urandom_range(0, 3), $urandom_range(0, 4), 1'b0);

        do_instr(4'b1111, 2'b00, 0, 0, 1'b0);
        mem_ready = 1'b1;
        step(ST_HALT, 1'b1, ST_FETCH, 1'b1);

        do_instr(4'b1111, 2'b00, 0, 0, 1'b1);
        for (int i = 0; i < 60; i++)
            do_instr(4'($urandom_range(0, 15)), 2'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b1);

        wait_cnt = 0;
        while (sb_q.size() > 0 && wait_cnt < 5) begin
            @(posedge clk);
            wait_cnt++;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
